// File: rtl/cruise_control_fsm.sv
// Cruise-control controller: tracks a modelled vehicle speed and regulates it
// toward a stored setpoint from pedal and steering-wheel button inputs.
module cruise_control_fsm #(
    parameter int SPEED_W    = 8,
    parameter int MIN_SPEED  = 45,
    parameter int MAX_SPEED  = 200,
    parameter int BRAKE_STEP = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cruise_on,
    input  logic               throttle,
    input  logic               brake,
    input  logic               set,
    input  logic               accel,
    input  logic               coast,
    input  logic               cancel,
    input  logic               resume,
    output logic [SPEED_W-1:0] speed,
    output logic [SPEED_W-1:0] cruise_speed,
    output logic               cruise_active,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CRUISE  = 3'd2,
        ST_ACCEL   = 3'd3,
        ST_COAST   = 3'd4,
        ST_STANDBY = 3'd5
    } state_t;

    localparam logic [SPEED_W:0]   MAX_W   = (SPEED_W+1)'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] MAX_V   = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] MIN_V   = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] BRAKE_V = SPEED_W'(BRAKE_STEP);
    localparam logic [SPEED_W-1:0] ONE_V   = SPEED_W'(1);

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] cruise_speed_q, cruise_speed_d;
    logic               valid_q, valid_d;

    // One extra bit of headroom so carry/borrow can be clamped instead of wrapping.
    function automatic logic [SPEED_W-1:0] sat_add(input logic [SPEED_W-1:0] a,
                                                   input logic [SPEED_W-1:0] b);
        logic [SPEED_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > MAX_W) ? MAX_V : s[SPEED_W-1:0];
    endfunction

    function automatic logic [SPEED_W-1:0] sat_sub(input logic [SPEED_W-1:0] a,
                                                   input logic [SPEED_W-1:0] b);
        logic [SPEED_W:0] s;
        s = {1'b0, a} - {1'b0, b};
        return s[SPEED_W] ? '0 : s[SPEED_W-1:0];
    endfunction

    logic [SPEED_W-1:0] speed_inc, speed_dec, coast_set;
    logic               stop_req, can_set;

    always_comb begin
        speed_inc = sat_add(speed_q, ONE_V);
        speed_dec = sat_sub(speed_q, ONE_V);
        coast_set = (speed_dec < MIN_V) ? MIN_V : speed_dec;
        stop_req  = brake | cancel;
        can_set   = set & (speed_q >= MIN_V);
    end

    always_comb begin
        speed_d = speed_q;
        if (brake) begin
            speed_d = sat_sub(speed_q, BRAKE_V);
        end else begin
            case (state_q)
                ST_CRUISE: begin
                    if (throttle || speed_q < cruise_speed_q) speed_d = speed_inc;
                    else if (speed_q > cruise_speed_q)        speed_d = speed_dec;
                end
                ST_ACCEL: speed_d = speed_inc;
                ST_COAST: speed_d = (speed_q > MIN_V) ? speed_dec : speed_q;
                default:  speed_d = throttle ? speed_inc : speed_dec;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        cruise_speed_d = cruise_speed_q;
        valid_d        = valid_q;
        if (!cruise_on) begin
            state_d        = ST_OFF;
            cruise_speed_d = '0;
            valid_d        = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (!stop_req && can_set) begin
                        state_d        = ST_CRUISE;
                        cruise_speed_d = speed_q;
                        valid_d        = 1'b1;
                    end
                end
                ST_CRUISE: begin
                    if (stop_req)    state_d = ST_STANDBY;
                    else if (set)    cruise_speed_d = speed_q;
                    else if (resume) state_d = ST_CRUISE;
                    else if (accel)  state_d = ST_ACCEL;
                    else if (coast)  state_d = ST_COAST;
                end
                ST_ACCEL: begin
                    if (stop_req) begin
                        state_d = ST_STANDBY;
                    end else begin
                        cruise_speed_d = speed_inc;
                        if (!accel) state_d = ST_CRUISE;
                    end
                end
                ST_COAST: begin
                    if (stop_req) begin
                        state_d = ST_STANDBY;
                    end else begin
                        cruise_speed_d = coast_set;
                        if (!coast) state_d = ST_CRUISE;
                    end
                end
                ST_STANDBY: begin
                    if (!stop_req) begin
                        if (can_set) begin
                            state_d        = ST_CRUISE;
                            cruise_speed_d = speed_q;
                            valid_d        = 1'b1;
                        end else if (resume && valid_q) begin
                            state_d = ST_CRUISE;
                        end
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_OFF;
            speed_q        <= '0;
            cruise_speed_q <= '0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            speed_q        <= speed_d;
            cruise_speed_q <= cruise_speed_d;
            valid_q        <= valid_d;
        end
    end

    assign speed         = speed_q;
    assign cruise_speed  = cruise_speed_q;
    assign state         = state_q;
    assign cruise_active = (state_q == ST_CRUISE) || (state_q == ST_ACCEL) ||
                           (state_q == ST_COAST);

endmodule
